hd_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready output channel between NUM_REQ valid/ready requesters. Arbitration is packet-granular: once a requester wins, it owns the channel until its `in_last` beat is accepted. The output is a single registered stage, so downstream always sees registered valid, data, last and source signals. It sits upstream of the team's handshake receiver/skid stages, which consume its output channel.

---
 rtl/hd_rr_arbiter.sv | 92 +++++++++
 tb/tb_hd_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hd_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_REQ valid/ready requesters share one
// registered valid/ready output channel; a winner owns the channel until its last beat.
module hd_rr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [IDX_W-1:0]              out_src,
  input  logic                          out_ready,
  output logic                          busy
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_owner;

  logic             w_ld;
  logic             w_found;
  logic             w_acc;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_sel;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  assign w_ld = ~out_valid | out_ready;

  // Descending scan so the last hit written is the first valid requester at or after r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (in_valid[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_cand  = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_sel = (r_state == ST_LOCKED) ? r_owner : w_cand;
  assign w_acc = w_ld & in_valid[w_sel];
  assign busy  = (r_state == ST_LOCKED);

  always_comb begin
    in_ready = '0;
    if (w_ld && ((r_state == ST_LOCKED) || w_found)) in_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      if (w_acc) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
        out_last  <= in_last[w_sel];
        out_src   <= w_sel;
        if (in_last[w_sel]) begin
          r_state <= ST_IDLE;
          r_ptr   <= wrap_add(w_sel, 1);
        end else if (r_state == ST_IDLE) begin
          r_state <= ST_LOCKED;
          r_owner <= w_sel;
        end
      end else if (w_ld) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hd_rr_arbiter.sv
// Bench for hd_rr_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a rotation-order reference model.
module tb_hd_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_last = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_src;
  logic          out_ready = 1'b0;
  logic          busy;

  hd_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] src;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t tbl[18];

  // reference model state
  int          m_ptr, m_owner;
  logic        m_ov, m_ol;
  logic [31:0] m_od;
  int          m_os;

  task automatic model_step(output logic [3:0] er);
    int   g;
    logic mld;
    mld = !m_ov || out_ready;
    g   = -1;
    er  = '0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (mld && g >= 0) er[g] = 1'b1;
    end else begin
      g = m_owner;
      if (mld) er[g] = 1'b1;
    end
    if (mld && g >= 0 && in_valid[g]) begin
      m_ov = 1'b1;
      m_od = in_data[g*DW +: DW];
      m_ol = in_last[g];
      m_os = g;
      if (in_last[g]) begin
        m_owner = -1;
        m_ptr   = (g + 1) % N;
      end else begin
        m_owner = g;
      end
    end else if (mld) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] er;
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[6]  = '{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[7]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[10] = '{4'b1000, 4'b1000, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[11] = '{4'b1000, 4'b1000, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[12] = '{4'b1000, 4'b1000, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[13] = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[15] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[16] = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[17] = '{4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};

    // reset state
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_src", out_src, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      in_valid  = tbl[r].v;
      in_last   = tbl[r].l;
      out_ready = tbl[r].ordy;
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'hA000_0000 | (i << 8) | r;
      #1 check($sformatf("tbl%0d in_ready", r), in_ready, tbl[r].rdy);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d out_valid", r), out_valid, tbl[r].ov);
      check($sformatf("tbl%0d busy", r), busy, tbl[r].busy);
      if (tbl[r].ov) begin
        check($sformatf("tbl%0d out_src", r), out_src, tbl[r].src);
        check($sformatf("tbl%0d out_last", r), out_last, tbl[r].last);
        check($sformatf("tbl%0d out_data", r), out_data,
              32'hA000_0000 | (32'(tbl[r].src) << 8) | r);
      end
    end

    // backpressure: hold 0xDEADBEEF for 5 cycles
    @(negedge clk);
    in_valid = 4'b0010;
    in_last  = 4'b0010;
    in_data[1*DW +: DW] = 32'hDEADBEEF;
    #1 check("bp first in_ready", in_ready, 4'b0010);
    @(posedge clk);
    #1 check("bp load data", out_data, 32'hDEADBEEF);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data[2*DW +: DW] = 32'h2222_0002;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
      check("bp out_data", out_data, 32'hDEADBEEF);
      check("bp out_src", out_src, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", in_ready, 4'b0100);
    @(posedge clk);
    #1;
    check("bp advance data", out_data, 32'h2222_0002);
    check("bp advance src", out_src, 2);

    // asynchronous reset mid-packet
    @(negedge clk);
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    @(posedge clk);
    #1;
    check("mid busy", busy, 1);
    check("mid out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", out_valid, 0);
    check("arst busy", busy, 0);
    check("arst out_src", out_src, 0);
    check("arst out_data", out_data, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    #1 check("post-rst in_ready", in_ready, 4'b0001);
    @(posedge clk);
    #1 check("post-rst out_src", out_src, 0);

    // randomized traffic against the reference model
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = '0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_ptr   = 0;
    m_owner = -1;
    m_ov    = 1'b0;
    m_ol    = 1'b0;
    m_od    = '0;
    m_os    = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd out_valid", out_valid, m_ov);
      check("rnd busy", busy, m_owner >= 0);
      if (m_ov) begin
        check("rnd out_data", out_data, m_od);
        check("rnd out_src", out_src, m_os);
        check("rnd out_last", out_last, m_ol);
      end
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 9) < 7);
        in_last[i]  = ($urandom_range(0, 2) == 0);
        in_data[i*DW +: DW] = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_step(er);
      check("rnd in_ready", in_ready, er);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
